// File: rtl/sram_access_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : sram_access_ctrl
// Brief   : Load/store front end for a 128x32 level-sensitive SRAM with timed
//           read/write pulses, lane masking and load-data extension.
// Rev     : 1.0  initial release
// ============================================================================
module sram_access_ctrl #(
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned PULSE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [8:0]  req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [6:0]  sram_addr_sel,
  output logic [3:0]  sram_byte_sel,
  output logic [31:0] sram_datain,
  output logic        sram_read_pulse,
  output logic        sram_write_pulse,
  input  logic [31:0] sram_dataout
);

  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_setup = 3'd1;
  localparam logic [2:0] c_pulse = 3'd2;
  localparam logic [2:0] c_hold  = 3'd3;
  localparam logic [2:0] c_resp  = 3'd4;

  localparam logic [3:0] c_setup_load = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] c_pulse_load = 4'(PULSE_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] rdata_cap_q, rdata_cap_d;
  logic [6:0]  sram_addr_sel_q, sram_addr_sel_d;
  logic [3:0]  sram_byte_sel_q, sram_byte_sel_d;
  logic [31:0] sram_datain_q, sram_datain_d;
  logic        sram_read_pulse_q, sram_read_pulse_d;
  logic        sram_write_pulse_q, sram_write_pulse_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        w_req_err;
  logic [3:0]  w_mask;

  function automatic logic [3:0] lane_mask(input logic [1:0] lo, input logic [1:0] size);
    case (size)
      2'b00:   lane_mask = 4'b0001 << lo;
      2'b01:   lane_mask = lo[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_bits(input logic [3:0] m);
    lane_bits = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  // Right-align the addressed lane(s) of the captured word, then extend.
  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] lo,
                                          input logic [1:0] size, input logic uns);
    logic [31:0] s;
    s = word >> {lo, 3'b000};
    case (size)
      2'b00:   extract = uns ? {24'h0, s[7:0]}   : {{24{s[7]}}, s[7:0]};
      2'b01:   extract = uns ? {16'h0, s[15:0]}  : {{16{s[15]}}, s[15:0]};
      default: extract = word;
    endcase
  endfunction

  assign w_req_err = (req_size == 2'b11)
                  || ((req_size == 2'b01) && req_addr[0])
                  || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  assign w_mask    = lane_mask(req_addr[1:0], req_size);

  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    we_d               = we_q;
    addr_lo_d          = addr_lo_q;
    size_d             = size_q;
    uns_d              = uns_q;
    rdata_cap_d        = rdata_cap_q;
    sram_addr_sel_d    = sram_addr_sel_q;
    sram_byte_sel_d    = sram_byte_sel_q;
    sram_datain_d      = sram_datain_q;
    sram_read_pulse_d  = sram_read_pulse_q;
    sram_write_pulse_d = sram_write_pulse_q;
    rsp_valid_d        = rsp_valid_q;
    rsp_rdata_d        = rsp_rdata_q;
    rsp_err_d          = rsp_err_q;

    case (state_q)
      c_idle: begin
        if (req_valid) begin
          we_d      = req_we;
          addr_lo_d = req_addr[1:0];
          size_d    = req_size;
          uns_d     = req_unsigned;
          if (w_req_err) begin
            state_d     = c_resp;
            cnt_d       = 4'd0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end else begin
            state_d         = c_setup;
            cnt_d           = c_setup_load;
            sram_addr_sel_d = req_addr[8:2];
            sram_byte_sel_d = w_mask;
            sram_datain_d   = (req_wdata << {req_addr[1:0], 3'b000}) & lane_bits(w_mask);
          end
        end
      end
      c_setup: begin
        if (cnt_q == 4'd0) begin
          state_d            = c_pulse;
          cnt_d              = c_pulse_load;
          sram_write_pulse_d = we_q;
          sram_read_pulse_d  = !we_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      c_pulse: begin
        if (cnt_q == 4'd0) begin
          state_d            = c_hold;
          cnt_d              = 4'd0;
          sram_write_pulse_d = 1'b0;
          sram_read_pulse_d  = 1'b0;
          if (!we_q) begin
            rdata_cap_d = sram_dataout;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      c_hold: begin
        state_d     = c_resp;
        cnt_d       = 4'd0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = we_q ? 32'h0 : extract(rdata_cap_q, addr_lo_q, size_q, uns_q);
      end
      c_resp: begin
        state_d         = c_idle;
        cnt_d           = 4'd0;
        rsp_valid_d     = 1'b0;
        rsp_err_d       = 1'b0;
        rsp_rdata_d     = 32'h0;
        sram_addr_sel_d = 7'h0;
        sram_byte_sel_d = 4'h0;
        sram_datain_d   = 32'h0;
      end
      default: begin
        state_d = c_idle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= c_idle;
      cnt_q              <= 4'd0;
      we_q               <= 1'b0;
      addr_lo_q          <= 2'b00;
      size_q             <= 2'b00;
      uns_q              <= 1'b0;
      rdata_cap_q        <= 32'h0;
      sram_addr_sel_q    <= 7'h0;
      sram_byte_sel_q    <= 4'h0;
      sram_datain_q      <= 32'h0;
      sram_read_pulse_q  <= 1'b0;
      sram_write_pulse_q <= 1'b0;
      rsp_valid_q        <= 1'b0;
      rsp_rdata_q        <= 32'h0;
      rsp_err_q          <= 1'b0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      we_q               <= we_d;
      addr_lo_q          <= addr_lo_d;
      size_q             <= size_d;
      uns_q              <= uns_d;
      rdata_cap_q        <= rdata_cap_d;
      sram_addr_sel_q    <= sram_addr_sel_d;
      sram_byte_sel_q    <= sram_byte_sel_d;
      sram_datain_q      <= sram_datain_d;
      sram_read_pulse_q  <= sram_read_pulse_d;
      sram_write_pulse_q <= sram_write_pulse_d;
      rsp_valid_q        <= rsp_valid_d;
      rsp_rdata_q        <= rsp_rdata_d;
      rsp_err_q          <= rsp_err_d;
    end
  end

  assign req_ready        = (state_q == c_idle) && !rst;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_rdata        = rsp_rdata_q;
  assign rsp_err          = rsp_err_q;
  assign sram_addr_sel    = sram_addr_sel_q;
  assign sram_byte_sel    = sram_byte_sel_q;
  assign sram_datain      = sram_datain_q;
  assign sram_read_pulse  = sram_read_pulse_q;
  assign sram_write_pulse = sram_write_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_access_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_sram_access_ctrl
// Brief   : Scoreboard bench for sram_access_ctrl with a behavioural SRAM.
// Rev     : 1.0  initial release
// ============================================================================
module tb_sram_access_ctrl;
  localparam int S = 1;
  localparam int P = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [8:0]  req_addr = 9'h0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [6:0]  sram_addr_sel;
  logic [3:0]  sram_byte_sel;
  logic [31:0] sram_datain;
  logic        sram_read_pulse;
  logic        sram_write_pulse;
  logic [31:0] sram_dataout;

  sram_access_ctrl #(.SETUP_CYCLES(S), .PULSE_CYCLES(P)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sram_addr_sel(sram_addr_sel), .sram_byte_sel(sram_byte_sel),
    .sram_datain(sram_datain), .sram_read_pulse(sram_read_pulse),
    .sram_write_pulse(sram_write_pulse), .sram_dataout(sram_dataout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Level-sensitive SRAM model: lanes written while the write pulse is high.
  logic [31:0] mem [128];
  initial for (int i = 0; i < 128; i++) mem[i] = 32'h0;
  always @(negedge clk) begin
    if (sram_write_pulse)
      for (int k = 0; k < 4; k++)
        if (sram_byte_sel[k]) mem[sram_addr_sel][8*k +: 8] <= sram_datain[8*k +: 8];
  end
  assign sram_dataout = mem[sram_addr_sel];

  typedef struct { logic [31:0] rdata; logic err; int cyc; } rsp_t;
  typedef struct { logic we; logic [6:0] asel; logic [3:0] bsel; logic [31:0] din; } pulse_t;
  rsp_t   rsp_q[$];
  pulse_t pq[$];

  int n_chk = 0, n_pass = 0, n_issued = 0, n_acc = 0;
  logic abort = 1'b0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic issue(input logic we, input logic [8:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata, input logic [3:0] bsel,
                       input logic [31:0] din, input logic [31:0] rdata, input logic err,
                       input logic exp_rsp, input logic hold, output int waited);
    rsp_t   r;
    pulse_t p;
    int     n;
    req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
    req_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 200);
    waited = n;
    if (!req_ready) begin
      chk("accept_timeout", 80'(req_ready), 80'(1));
      req_valid = 1'b0;
      return;
    end
    n_issued++;
    if (exp_rsp) begin
      r.rdata = rdata; r.err = err;
      r.cyc = cyc + (err ? 1 : S + P + 2);
      rsp_q.push_back(r);
    end
    if (!err) begin
      p.we = we; p.asel = addr[8:2]; p.bsel = bsel; p.din = din;
      pq.push_back(p);
    end
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  initial begin
    int w;
    int k;
    fork
      begin : stim
        repeat (2) @(negedge clk);
        chk("reset_outputs", 80'({req_ready, rsp_valid, rsp_err, rsp_rdata, sram_addr_sel,
                                  sram_byte_sel, sram_datain, sram_read_pulse, sram_write_pulse}), 80'(0));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 80'(req_ready), 80'(1));
        @(posedge clk); #1;

        // we addr    size  uns wdata         bsel     din           rdata         err
        issue(1, 9'h010, 2'b10, 0, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'h0,        0, 1, 0, w);
        issue(0, 9'h010, 2'b10, 0, 32'h0,        4'b1111, 32'h0,        32'hDEADBEEF, 0, 1, 0, w);
        issue(1, 9'h013, 2'b00, 0, 32'h00000080, 4'b1000, 32'h80000000, 32'h0,        0, 1, 0, w);
        issue(0, 9'h013, 2'b00, 0, 32'h0,        4'b1000, 32'h0,        32'hFFFFFF80, 0, 1, 0, w);
        issue(0, 9'h013, 2'b00, 1, 32'h0,        4'b1000, 32'h0,        32'h00000080, 0, 1, 0, w);
        issue(1, 9'h010, 2'b10, 0, 32'h1234ABCD, 4'b1111, 32'h1234ABCD, 32'h0,        0, 1, 0, w);
        issue(0, 9'h012, 2'b01, 0, 32'h0,        4'b1100, 32'h0,        32'h00001234, 0, 1, 0, w);
        issue(0, 9'h010, 2'b01, 0, 32'h0,        4'b0011, 32'h0,        32'hFFFFABCD, 0, 1, 0, w);
        issue(0, 9'h010, 2'b01, 1, 32'h0,        4'b0011, 32'h0,        32'h0000ABCD, 0, 1, 0, w);
        issue(0, 9'h011, 2'b00, 0, 32'h0,        4'b0010, 32'h0,        32'hFFFFFFAB, 0, 1, 0, w);
        issue(1, 9'h020, 2'b01, 0, 32'hFFFF8001, 4'b0011, 32'h00008001, 32'h0,        0, 1, 0, w);
        issue(0, 9'h020, 2'b10, 0, 32'h0,        4'b1111, 32'h0,        32'h00008001, 0, 1, 0, w);
        issue(0, 9'h021, 2'b00, 1, 32'h0,        4'b0010, 32'h0,        32'h00000080, 0, 1, 0, w);
        // Misaligned and illegal-size requests.
        issue(0, 9'h001, 2'b01, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 1, 0, w);
        issue(1, 9'h006, 2'b10, 0, 32'h55555555, 4'b0000, 32'h0,        32'h0,        1, 1, 0, w);
        issue(0, 9'h008, 2'b11, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 1, 0, w);

        // Back-to-back with req_valid held high; B's fields change right after A is taken.
        issue(0, 9'h010, 2'b10, 0, 32'h0,        4'b1111, 32'h0,        32'h1234ABCD, 0, 1, 1, w);
        issue(0, 9'h012, 2'b00, 1, 32'h0,        4'b0100, 32'h0,        32'h00000034, 0, 1, 0, w);
        chk("b2b_ready_wait", 80'(w), 80'(S + P + 3));

        // Abort a read in its second pulse cycle.
        issue(0, 9'h010, 2'b10, 0, 32'h0,        4'b1111, 32'h0,        32'h0,        0, 0, 0, w);
        @(posedge clk); @(posedge clk);
        #1 abort = 1'b1; rst = 1'b1;
        #1 chk("abort_outputs", 80'({sram_read_pulse, sram_write_pulse, rsp_valid, req_ready}), 80'(0));
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_abort", 80'(req_ready), 80'(1));
        @(posedge clk); #1 abort = 1'b0;
        issue(0, 9'h020, 2'b10, 0, 32'h0,        4'b1111, 32'h0,        32'h00008001, 0, 1, 0, w);

        k = 0;
        while ((rsp_q.size() != 0 || pq.size() != 0) && k < 100) begin @(negedge clk); k++; end
        repeat (3) @(negedge clk);
        chk("drain", 80'(rsp_q.size() + pq.size()), 80'(0));
        chk("accept_count", 80'(n_acc), 80'(n_issued));
      end
      begin : mon
        pulse_t p;
        rsp_t   r;
        logic   act, prev_act;
        int     width;
        prev_act = 1'b0;
        width = 0;
        forever begin
          @(negedge clk);
          if (req_valid && req_ready) n_acc++;
          if (rsp_valid) begin
            if (rsp_q.size() == 0) chk("rsp_unexpected", 80'(rsp_valid), 80'(0));
            else begin
              r = rsp_q.pop_front();
              chk("rsp_rdata", 80'(rsp_rdata), 80'(r.rdata));
              chk("rsp_err", 80'(rsp_err), 80'(r.err));
              chk("rsp_latency", 80'(cyc), 80'(r.cyc));
            end
          end
          act = sram_read_pulse | sram_write_pulse;
          if (act && !prev_act) begin
            width = 1;
            if (pq.size() == 0) chk("pulse_unexpected", 80'(act), 80'(0));
            else begin
              p = pq.pop_front();
              chk("pulse_kind", 80'({sram_write_pulse, sram_read_pulse}), 80'(p.we ? 2'b10 : 2'b01));
              chk("addr_sel", 80'(sram_addr_sel), 80'(p.asel));
              chk("byte_sel", 80'(sram_byte_sel), 80'(p.bsel));
              if (p.we) chk("datain", 80'(sram_datain), 80'(p.din));
            end
          end else if (act) begin
            width++;
          end else if (prev_act && !abort) begin
            chk("pulse_width", 80'(width), 80'(P));
          end
          prev_act = act;
        end
      end
    join_any
    disable fork;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
